// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store unit between a pipeline request port and a single-port,
// word-organised data memory with combinational read data. Byte and halfword
// stores are done as read-modify-write.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   req_valid / req_ready       request handshake (ready only in IDLE)
//   req_write, req_size,        store/load, size (00 B, 01 H, 1x W),
//   req_signed, req_addr,       sign-extend sub-word loads, byte address,
//   req_wdata                   right-aligned store data
//   rsp_valid, rsp_rdata,       one-cycle completion pulse, load result
//   rsp_err                     (0 for stores), misaligned-access flag
//   mem_addr, mem_write,        word index, write strobe,
//   mem_wdata, mem_rdata        write word, same-cycle read word
//
// Build option
//   MISALIGN_TRAP_EN  defined: misaligned halfword/word accesses complete
//                     with rsp_err = 1 and never touch memory.
//                     undefined: rsp_err stays 0 and misaligned addresses
//                     are aligned down before the access.
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_WRITE  = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   logic [1:0]        state_r;
   logic              write_r;
   logic              word_r;
   logic              half_r;
   logic              signed_r;
   logic [1:0]        off_r;
   logic [31:0]       wdata_r;
   logic              rsp_valid_r;
   logic [31:0]       rsp_rdata_r;
   logic              rsp_err_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic              mem_write_r;
   logic [31:0]       mem_wdata_r;

   logic              size_word_s;
   logic              size_half_s;
   logic [1:0]        off_s;
   logic              trap_s;
   logic              unused_addr_s;

   // Pick the addressed lane out of a memory word and extend it to 32 bits.
   function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic        is_word,
                                                input logic        is_half,
                                                input logic        is_signed);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'h00;
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      if (is_word)
         return word;
      else if (is_half)
         return {{16{is_signed & h[15]}}, h};
      else
         return {{24{is_signed & b[7]}}, b};
   endfunction

   // Replace the addressed lane of an old memory word with new store data.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  off,
                                              input logic        is_word,
                                              input logic        is_half);
      logic [31:0] merged;
      if (is_word)
         merged = wd;
      else if (is_half)
         merged = off[1] ? {wd[15:0], old_word[15:0]} : {old_word[31:16], wd[15:0]};
      else begin
         case (off)
            2'd0:    merged = {old_word[31:8], wd[7:0]};
            2'd1:    merged = {old_word[31:16], wd[7:0], old_word[7:0]};
            2'd2:    merged = {old_word[31:24], wd[7:0], old_word[15:0]};
            2'd3:    merged = {wd[7:0], old_word[23:0]};
            default: merged = old_word;
         endcase
      end
      return merged;
   endfunction

   // Upper address bits wrap around the memory and are deliberately dropped.
   assign unused_addr_s = ^req_addr[31:ADDR_W+2];

   // Request decode: size class, aligned lane offset and misalignment trap.
   always_comb begin
      size_word_s = req_size[1];
      size_half_s = (req_size == 2'b01);
      if (size_word_s)
         off_s = 2'b00;
      else if (size_half_s)
         off_s = {req_addr[1], 1'b0};
      else
         off_s = req_addr[1:0];
`ifdef MISALIGN_TRAP_EN
      trap_s = (size_half_s & req_addr[0]) |
               (size_word_s & (req_addr[1:0] != 2'b00));
`else
      trap_s = 1'b0;
`endif
   end

   // Ready is a decode of IDLE, gated by reset so it reads 0 while held in
   // reset and 1 immediately after release.
   assign req_ready = rst & (state_r == ST_IDLE);
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;
   assign mem_addr  = mem_addr_r;
   assign mem_write = mem_write_r;
   assign mem_wdata = mem_wdata_r;

   // Access FSM with registered response and memory-side outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         write_r     <= 1'b0;
         word_r      <= 1'b0;
         half_r      <= 1'b0;
         signed_r    <= 1'b0;
         off_r       <= 2'b00;
         wdata_r     <= 32'h0000_0000;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
         rsp_err_r   <= 1'b0;
         mem_addr_r  <= '0;
         mem_write_r <= 1'b0;
         mem_wdata_r <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               rsp_valid_r <= 1'b0;
               rsp_err_r   <= 1'b0;
               rsp_rdata_r <= 32'h0000_0000;
               mem_write_r <= 1'b0;
               if (req_valid) begin
                  write_r    <= req_write;
                  word_r     <= size_word_s;
                  half_r     <= size_half_s;
                  signed_r   <= req_signed;
                  off_r      <= off_s;
                  wdata_r    <= req_wdata;
                  mem_addr_r <= req_addr[ADDR_W+1:2];
                  if (trap_s) begin
                     // Misaligned: report straight away, memory untouched.
                     state_r     <= ST_RESP;
                     rsp_valid_r <= 1'b1;
                     rsp_err_r   <= 1'b1;
                  end else begin
                     state_r <= ST_ACCESS;
                     // Word stores need no read, so the strobe goes out
                     // during ACCESS itself.
                     if (req_write && size_word_s) begin
                        mem_write_r <= 1'b1;
                        mem_wdata_r <= req_wdata;
                     end else begin
                        mem_write_r <= 1'b0;
                     end
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               if (write_r && word_r) begin
                  mem_write_r <= 1'b0;
                  rsp_valid_r <= 1'b1;
                  rsp_rdata_r <= 32'h0000_0000;
                  state_r     <= ST_RESP;
               end else if (write_r) begin
                  mem_write_r <= 1'b1;
                  mem_wdata_r <= lane_merge(mem_rdata, wdata_r, off_r, word_r, half_r);
                  state_r     <= ST_WRITE;
               end else begin
                  mem_write_r <= 1'b0;
                  rsp_valid_r <= 1'b1;
                  rsp_rdata_r <= lane_extract(mem_rdata, off_r, word_r, half_r, signed_r);
                  state_r     <= ST_RESP;
               end
            end
            ST_WRITE: begin
               mem_write_r <= 1'b0;
               rsp_valid_r <= 1'b1;
               rsp_rdata_r <= 32'h0000_0000;
               state_r     <= ST_RESP;
            end
            ST_RESP: begin
               mem_write_r <= 1'b0;
               rsp_valid_r <= 1'b0;
               rsp_err_r   <= 1'b0;
               rsp_rdata_r <= 32'h0000_0000;
               state_r     <= ST_IDLE;
            end
            default: begin
               mem_write_r <= 1'b0;
               rsp_valid_r <= 1'b0;
               rsp_err_r   <= 1'b0;
               rsp_rdata_r <= 32'h0000_0000;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit: directed scenarios followed by
// random accesses, all compared against a byte-level reference memory model.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int ADDR_W = 7;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_write;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic [31:0]       tb_mem  [DEPTH];
   logic [31:0]       ref_mem [DEPTH];
   int                write_count;
   logic              pl_en;
   logic [ADDR_W-1:0] pl_idx;
   logic [31:0]       pl_data;

   int errors;
   int checks;

   mem_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_addr   (mem_addr),
      .mem_write  (mem_write),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory seen by the DUT, with a bench-side preload port.
   assign mem_rdata = tb_mem[mem_addr];
   always @(posedge clk) begin
      if (pl_en)
         tb_mem[pl_idx] <= pl_data;
      else if (mem_write) begin
         tb_mem[mem_addr] <= mem_wdata;
         write_count      <= write_count + 1;
      end
   end
   initial write_count = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [ADDR_W-1:0] idx, input logic [31:0] data);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_data = data;
      @(negedge clk);
      pl_en = 1'b0;
      ref_mem[idx] = data;
   endtask

   // Reference behaviour from the access rules: byte counts, shifts and masks.
   task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] e_rdata, output logic e_err,
                        output int e_lat, output int e_writes);
      int          nbytes;
      int          lane;
      logic [63:0] mask64;
      logic [31:0] mask;
      logic [31:0] word;
      logic [31:0] v;
      logic [ADDR_W-1:0] idx;
      logic        mis;
      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      lane   = int'(addr[1:0]);
      mis    = (lane % nbytes) != 0;
      idx    = ADDR_W'((addr >> 2) % DEPTH);
`ifdef MISALIGN_TRAP_EN
      if (mis) begin
         e_rdata = 32'h0; e_err = 1'b1; e_lat = 1; e_writes = 0;
         return;
      end
`endif
      lane   = lane - (lane % nbytes);
      mask64 = (64'd1 << (8 * nbytes)) - 64'd1;
      mask   = mask64[31:0];
      word   = ref_mem[idx];
      e_err  = 1'b0;
      if (!wr) begin
         v = (word >> (8 * lane)) & mask;
         if (sg && nbytes < 4 && v[8 * nbytes - 1])
            v = v | ~mask;
         e_rdata = v; e_lat = 2; e_writes = 0;
      end else begin
         ref_mem[idx] = (word & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
         e_rdata = 32'h0; e_lat = (nbytes == 4) ? 2 : 3; e_writes = 1;
      end
   endtask

   task automatic do_access(input string tag, input logic wr, input logic [1:0] sz,
                            input logic sg, input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] e_rdata;
      logic        e_err;
      int          e_lat, e_writes, n, lat, wc0;
      logic [ADDR_W-1:0] idx;
      idx = ADDR_W'((addr >> 2) % DEPTH);
      model(wr, sz, sg, addr, wd, e_rdata, e_err, e_lat, e_writes);
      @(negedge clk);
      req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " ready"}, 32'(req_ready), 32'd1);
      wc0 = write_count;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 10);
      check({tag, " latency"}, 32'(lat), 32'(e_lat));
      check({tag, " rdata"}, rsp_rdata, e_rdata);
      check({tag, " err"}, 32'(rsp_err), 32'(e_err));
      @(negedge clk);
      check({tag, " pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, " writes"}, 32'(write_count - wc0), 32'(e_writes));
      check({tag, " mem"}, tb_mem[idx], ref_mem[idx]);
   endtask

   initial begin
      int          wc0;
      logic [1:0]  pat [6];
      logic [31:0] e_rd;
      logic        e_er;
      int          e_la, e_wr;
      errors = 0; checks = 0;
      rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      pl_en = 1'b0; pl_idx = '0; pl_data = 32'h0;

      // Preload memory while the DUT sits in reset.
      for (int i = 0; i < DEPTH; i++)
         poke(ADDR_W'(i), $urandom);

      // Reset state.
      check("rst ready", 32'(req_ready), 32'd0);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst rdata", rsp_rdata, 32'd0);
      check("rst err", 32'(rsp_err), 32'd0);
      check("rst mem_write", 32'(mem_write), 32'd0);
      check("rst mem_addr", 32'(mem_addr), 32'd0);
      check("rst mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1 check("release ready", 32'(req_ready), 32'd1);

      // Word and byte loads.
      poke(7'd5, 32'h8899AABB);
      do_access("lw 0x14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
      check("lw 0x14 value", rsp_rdata, 32'h0);
      do_access("lb 0x16", 1'b0, 2'b00, 1'b1, 32'h16, 32'h0);
      do_access("lbu 0x16", 1'b0, 2'b00, 1'b0, 32'h16, 32'h0);

      // Byte store via read-modify-write.
      poke(7'd2, 32'h11223344);
      do_access("sb 0x09", 1'b1, 2'b00, 1'b0, 32'h09, 32'h000000EE);
      check("sb 0x09 word", tb_mem[2], 32'h1122EE44);

      // Misaligned word load.
      do_access("lw 0x02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0);

      // Reset asserted during the WRITE state of a halfword store.
      poke(7'd3, 32'hCAFEBABE);
      wc0 = write_count;
      @(negedge clk);
      req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
      req_addr = 32'h0E; req_wdata = 32'h00001234; req_valid = 1'b1;
      check("abort ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 check("abort strobe armed", 32'(mem_write), 32'd1);
      rst = 1'b0;
      #1 check("abort mem_write", 32'(mem_write), 32'd0);
      check("abort ready low", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1 check("abort ready after", 32'(req_ready), 32'd1);
      check("abort mem", tb_mem[3], 32'hCAFEBABE);
      check("abort writes", 32'(write_count - wc0), 32'd0);
      @(negedge clk);
      check("abort no rsp", 32'(rsp_valid), 32'd0);

      // Back-to-back: req_valid held high across two loads.
      poke(7'd9, 32'h0BADF00D);
      model(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, e_rd, e_er, e_la, e_wr);
      pat = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
      req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h24; req_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("b2b ready/rsp c%0d", k), 32'({req_ready, rsp_valid}), 32'(pat[k]));
         if (rsp_valid)
            check($sformatf("b2b rdata c%0d", k), rsp_rdata, e_rd);
         @(negedge clk);
      end
      req_valid = 1'b0;
      @(negedge clk);

      // Random accesses, including wrapped upper address bits.
      for (int i = 0; i < 40; i++)
         do_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom, $urandom);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, the data-memory word-index width (128 words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, pipeline access request.
REQ-005 SHALL have port req_ready, output, 1, request accepted when high together with req_valid.
REQ-006 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2, access size: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
REQ-008 SHALL have port req_signed, input, 1, sign-extend sub-word loads when 1.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, 32, load result; 0 for stores.
REQ-013 SHALL have port rsp_err, output, 1, misaligned access flag, valid with rsp_valid.
REQ-014 SHALL have port mem_addr, output, ADDR_W, word index equal to req_addr[ADDR_W+1:2]; upper address bits are ignored (wrap).
REQ-015 SHALL have port mem_write, output, 1, word write strobe to data memory.
REQ-016 SHALL have port mem_wdata, output, 32, word written to data memory.
REQ-017 SHALL have port mem_rdata, input, 32, combinational read data for mem_addr, valid in the same cycle.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP.
REQ-019 SHALL drive req_ready = 1 only in IDLE; acceptance latches write, size, signed, addr and wdata, and moves the FSM to ACCESS.
REQ-020 SHALL, for a load in ACCESS, sample mem_rdata, select the byte/halfword lane little-endian by addr[1:0], zero- or sign-extend per req_signed, then go to RESP.
REQ-021 SHALL, for a word store in ACCESS, assert mem_write for exactly one cycle with mem_wdata = wdata, then go to RESP.
REQ-022 SHALL, for a byte/halfword store, read the word in ACCESS, merge the new lane into it, and go to WRITE; WRITE SHALL assert mem_write for one cycle with the merged word, then go to RESP.
REQ-023 SHALL assert rsp_valid for exactly one cycle in RESP and return to IDLE; rsp_valid rises 2 cycles after acceptance (3 cycles for sub-word stores).
REQ-024 SHALL hold mem_addr stable from ACCESS through WRITE and keep mem_write = 0 in IDLE and RESP.
REQ-025 SHALL ignore req_valid while not in IDLE; no request is queued.

Reset
REQ-026 SHALL, while rst = 0, force the FSM to IDLE and all outputs to 0 (req_ready = 0); after release, req_ready = 1 on the first cycle.
REQ-027 SHALL abort any in-flight access when reset is asserted, with no mem_write issued and no rsp_valid generated for that access.

Configuration
REQ-028 SHALL, with MISALIGN_TRAP_EN defined, treat halfword accesses with addr[0] = 1 and word accesses with addr[1:0] != 0 as misaligned: ACCESS is skipped, RESP is entered the next cycle with rsp_err = 1 and rsp_rdata = 0, and mem_write is never asserted.
REQ-029 SHALL, without MISALIGN_TRAP_EN, tie rsp_err to 0 and align misaligned addresses down (clear addr[0] for halfword, clear addr[1:0] for word), then process them normally.

Verification
REQ-030 SHALL cover a word load: mem[5] = 0x8899AABB, load word addr 0x14 -> rsp_valid 2 cycles after acceptance, rsp_rdata = 0x8899AABB.
REQ-031 SHALL cover a signed byte load: mem[5] = 0x8899AABB, lb addr 0x16 -> rsp_rdata = 0xFFFFFF99; lbu of the same address -> 0x00000099.
REQ-032 SHALL cover a byte store via read-modify-write: mem[2] = 0x11223344, sb 0xEE at addr 0x09 -> one mem_write pulse in WRITE, mem[2] = 0x1122EE44, rsp_valid 3 cycles after acceptance.
REQ-033 SHALL cover a misaligned word load: lw at addr 0x02 -> with MISALIGN_TRAP_EN, rsp_err = 1 and no mem_write; without it, word 0 is returned and rsp_err = 0.
REQ-034 SHALL cover reset mid-operation: rst low during WRITE of a halfword store -> no mem_write, memory unchanged, req_ready = 1 the cycle after release.
REQ-035 SHALL cover back-to-back requests: req_valid held high -> the second request is accepted only in the cycle after rsp_valid, with req_ready = 0 in between.
